// File: rtl/mem_arbiter_if.sv
// Request, fill-return and main-memory signals between the two caches,
// the memory arbiter and main memory.
interface mem_arbiter_if;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        dcache_req;
    logic        dcache_we;
    logic [15:0] dcache_addr;
    logic [15:0] dcache_wdata;
    logic        icache_grant;
    logic        dcache_grant;
    logic        icache_data_valid;
    logic        dcache_data_valid;
    logic [15:0] rdata;
    logic [2:0]  word_idx;
    logic        fill_done;
    logic        write_done;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;

    modport slave (
        input  icache_req, icache_addr, dcache_req, dcache_we, dcache_addr, dcache_wdata,
               mem_rdata, mem_data_valid,
        output icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
               rdata, word_idx, fill_done, write_done,
               mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output icache_req, icache_addr, dcache_req, dcache_we, dcache_addr, dcache_wdata,
               mem_rdata, mem_data_valid,
        input  icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
               rdata, word_idx, fill_done, write_done,
               mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache block
// fills and D-cache block fills / write-throughs.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);
    localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(BLOCK_WORDS);
    localparam logic [LAT_W-1:0] WR_LAST   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LAT_W-1:0] WR_PRE    = LAT_W'(MEM_LATENCY - 2);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t           state;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic [LAT_W-1:0] wr_cnt;
    logic             last_grant;   // 1: D-cache was served last
    logic [15:0]      base;
    logic             i_grant;
    logic             d_grant;
    logic             wr_done;
    logic             mem_en;
    logic             mem_we;
    logic [15:0]      mem_a;
    logic [15:0]      mem_d;
    logic             pick_d;
    logic             fill_valid;

    assign pick_d = bus.dcache_req && (!bus.icache_req || !last_grant);

    // Only returns that answer an outstanding read of the current fill count.
    assign fill_valid = (state == FILL) && bus.mem_data_valid && (recv_cnt < issue_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            wr_cnt     <= '0;
            last_grant <= 1'b0;
            base       <= '0;
            i_grant    <= 1'b0;
            d_grant    <= 1'b0;
            wr_done    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_d      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.icache_req || bus.dcache_req) begin
                        last_grant <= pick_d;
                        i_grant    <= !pick_d;
                        d_grant    <= pick_d;
                        mem_en     <= 1'b1;
                        if (pick_d && bus.dcache_we) begin
                            state   <= WRITE;
                            wr_cnt  <= '0;
                            wr_done <= (MEM_LATENCY == 1);
                            mem_we  <= 1'b1;
                            mem_a   <= bus.dcache_addr;
                            mem_d   <= bus.dcache_wdata;
                        end else begin
                            state     <= FILL;
                            base      <= (pick_d ? bus.dcache_addr : bus.icache_addr) & 16'hFFF0;
                            mem_a     <= (pick_d ? bus.dcache_addr : bus.icache_addr) & 16'hFFF0;
                            issue_cnt <= CNT_W'(1);
                            recv_cnt  <= '0;
                        end
                    end
                end
                FILL: begin
                    if (issue_cnt < ALL_WORDS) begin
                        mem_en    <= 1'b1;
                        mem_a     <= base + (16'(issue_cnt) << 1);
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end else begin
                        mem_en <= 1'b0;
                        mem_a  <= '0;
                    end
                    if (fill_valid) begin
                        if (recv_cnt == LAST_WORD) begin
                            state     <= IDLE;
                            i_grant   <= 1'b0;
                            d_grant   <= 1'b0;
                            issue_cnt <= '0;
                            recv_cnt  <= '0;
                            mem_en    <= 1'b0;
                            mem_a     <= '0;
                        end else begin
                            recv_cnt <= recv_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    mem_a  <= '0;
                    mem_d  <= '0;
                    if (wr_cnt == WR_LAST) begin
                        state   <= IDLE;
                        i_grant <= 1'b0;
                        d_grant <= 1'b0;
                        wr_done <= 1'b0;
                        wr_cnt  <= '0;
                    end else begin
                        wr_cnt  <= wr_cnt + LAT_W'(1);
                        wr_done <= (wr_cnt == WR_PRE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fill words pass straight from memory to the granted cache.
    assign bus.icache_data_valid = fill_valid && i_grant;
    assign bus.dcache_data_valid = fill_valid && d_grant;
    assign bus.rdata             = fill_valid ? bus.mem_rdata : '0;
    assign bus.word_idx          = fill_valid ? 3'(recv_cnt) : '0;
    assign bus.fill_done         = fill_valid && (recv_cnt == LAST_WORD);
    assign bus.write_done        = wr_done;
    assign bus.icache_grant      = i_grant;
    assign bus.dcache_grant      = d_grant;
    assign bus.mem_enable        = mem_en;
    assign bus.mem_wr            = mem_we;
    assign bus.mem_addr          = mem_a;
    assign bus.mem_wdata         = mem_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts every
// grant, memory access, fill word and done pulse; a monitor checks each cycle.
module tb_mem_arbiter;
    localparam int ML = 4;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LATENCY(ML), .BLOCK_WORDS(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { int cyc; bit wr; logic [15:0] addr; logic [15:0] wdata; } mem_ev_t;
    typedef struct { int cyc; int who; int idx; logic [15:0] data; } data_ev_t;
    typedef struct { int cyc; int kind; } done_ev_t;
    typedef struct { int who; int start; int stop; } grant_ev_t;
    typedef struct { int due; logic [15:0] data; } ret_t;

    mem_ev_t   mq[$];
    data_ev_t  dq[$];
    done_ev_t  doneq[$];
    grant_ev_t gq[$];
    ret_t      pq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur = 0;

    bit          pend[2], acc[2], drop[2];
    logic [15:0] raddr[2];
    bit          d_we;
    logic [15:0] d_wdata;
    bit          m_busy, m_last;
    int          m_t0, m_end, m_who;
    bit          rst_next, rst_q, post_rst, mon_en, rand_mode, force_drop_i;
    int          rearm_d;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_i(input logic [15:0] a);
        pend[0] = 1'b1; raddr[0] = a;
    endtask

    task automatic set_d(input bit we, input logic [15:0] a, input logic [15:0] wd);
        pend[1] = 1'b1; raddr[1] = a; d_we = we; d_wdata = wd;
    endtask

    // Model: accepted transaction expands into its full timeline of events.
    task automatic accept(input int w);
        logic [15:0] base;
        mem_ev_t me; data_ev_t de; done_ev_t ne; grant_ev_t ge;
        m_last = (w == 1); m_busy = 1'b1; m_who = w; acc[w] = 1'b1; m_t0 = cur + 1;
        drop[w] = (w == 0 && force_drop_i) || (rand_mode && $urandom_range(3) == 0);
        if (w == 0) force_drop_i = 1'b0;
        if (w == 1 && d_we) begin
            m_end = m_t0 + ML - 1;
            me.cyc = m_t0; me.wr = 1'b1; me.addr = raddr[1]; me.wdata = d_wdata;
            mq.push_back(me);
            ne.cyc = m_end; ne.kind = 1; doneq.push_back(ne);
        end else begin
            base = {raddr[w][15:4], 4'h0};
            m_end = m_t0 + BW + ML - 1;
            for (int k = 0; k < BW; k++) begin
                me.cyc = m_t0 + k; me.wr = 1'b0; me.addr = base + 16'(2 * k); me.wdata = '0;
                mq.push_back(me);
                de.cyc = m_t0 + ML + k; de.who = w; de.idx = k; de.data = mem_word(base + 16'(2 * k));
                dq.push_back(de);
            end
            ne.cyc = m_end; ne.kind = 0; doneq.push_back(ne);
        end
        ge.who = w; ge.start = m_t0; ge.stop = m_end; gq.push_back(ge);
    endtask

    task automatic step();
        bit req0, req1;
        @(posedge clk); #1;
        cur = cyc;
        post_rst = rst_q;
        if (rst_q) begin
            mq.delete(); dq.delete(); doneq.delete(); gq.delete();
            m_busy = 1'b0; m_last = 1'b0;
            for (int r = 0; r < 2; r++) begin pend[r] = 0; acc[r] = 0; drop[r] = 0; end
        end else if (m_busy && cur == m_end + 1) begin
            pend[m_who] = 1'b0; acc[m_who] = 1'b0; drop[m_who] = 1'b0; m_busy = 1'b0;
            if (m_who == 1 && rearm_d > 0) begin
                rearm_d--; set_d(1'b0, raddr[1] + 16'h0040, 16'h0);
            end
        end
        if (rand_mode) begin
            if (!pend[0] && $urandom_range(7) == 0) set_i(16'($urandom));
            if (!pend[1] && $urandom_range(7) == 0)
                set_d(1'($urandom_range(1)), 16'($urandom), 16'($urandom));
        end
        rst_q = rst_next;
        rst = rst_next;
        req0 = pend[0] && !(acc[0] && drop[0]);
        req1 = pend[1] && !(acc[1] && drop[1]);
        bus.icache_req   = req0;
        bus.icache_addr  = raddr[0];
        bus.dcache_req   = req1;
        bus.dcache_we    = d_we;
        bus.dcache_addr  = raddr[1];
        bus.dcache_wdata = d_wdata;
        if (!rst_q && !m_busy && (req0 || req1))
            accept((req1 && (!req0 || !m_last)) ? 1 : 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_busy || pend[0] || pend[1]) && n < 300) begin step(); n++; end
        if (m_busy || pend[0] || pend[1]) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Main memory: fixed-latency reads, plus stray valids when nothing is outstanding.
    initial begin
        ret_t r;
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) begin
                r.due = cyc + ML; r.data = mem_word(bus.mem_addr); pq.push_back(r);
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                r = pq.pop_front();
                bus.mem_data_valid = 1'b1; bus.mem_rdata = r.data;
            end else if (pq.size() == 0 && $urandom_range(3) == 0) begin
                bus.mem_data_valid = 1'b1; bus.mem_rdata = 16'($urandom);
            end else begin
                bus.mem_data_valid = 1'b0; bus.mem_rdata = '0;
            end
        end
    end

    // Monitor: pop what is due this cycle and compare every output.
    initial forever begin
        mem_ev_t me; data_ev_t de; done_ev_t ne;
        bit ex;
        logic [1:0] ev;
        @(negedge clk);
        if (mon_en) begin
            if (post_rst)
                chk("reset_outputs", 64'({bus.icache_grant, bus.dcache_grant, bus.icache_data_valid,
                    bus.dcache_data_valid, bus.rdata, bus.word_idx, bus.fill_done, bus.write_done,
                    bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 64'd0);
            ex = mq.size() > 0 && mq[0].cyc == cyc;
            chk("mem_enable", 64'(bus.mem_enable), 64'(ex));
            if (ex) begin
                me = mq.pop_front();
                chk("mem_access", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 64'({me.wr, me.addr, me.wdata}));
            end else begin
                chk("mem_idle", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 64'd0);
            end
            ex = dq.size() > 0 && dq[0].cyc == cyc;
            ev = 2'b00;
            if (ex) begin
                de = dq.pop_front();
                ev = (de.who == 1) ? 2'b10 : 2'b01;
                chk("fill_word", 64'({bus.word_idx, bus.rdata}), 64'({3'(de.idx), de.data}));
            end
            chk("data_valid", 64'({bus.dcache_data_valid, bus.icache_data_valid}), 64'(ev));
            ev = 2'b00;
            if (doneq.size() > 0 && doneq[0].cyc == cyc) begin
                ne = doneq.pop_front();
                ev = (ne.kind == 0) ? 2'b10 : 2'b01;
            end
            chk("done_pulse", 64'({bus.fill_done, bus.write_done}), 64'(ev));
            while (gq.size() > 0 && gq[0].stop < cyc) void'(gq.pop_front());
            ev = 2'b00;
            if (gq.size() > 0 && gq[0].start <= cyc) ev = (gq[0].who == 1) ? 2'b10 : 2'b01;
            chk("grant", 64'({bus.dcache_grant, bus.icache_grant}), 64'(ev));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 2; r++) begin pend[r] = 0; acc[r] = 0; drop[r] = 0; raddr[r] = '0; end
        d_we = 0; d_wdata = '0; m_busy = 0; m_last = 0; m_t0 = 0; m_end = 0; m_who = 0;
        rst_q = 0; post_rst = 0; mon_en = 0; rand_mode = 0; force_drop_i = 0; rearm_d = 0;
        rst = 1'b1; rst_next = 1'b1;
        bus.icache_req = 0; bus.icache_addr = '0; bus.dcache_req = 0;
        bus.dcache_we = 0; bus.dcache_addr = '0; bus.dcache_wdata = '0;
        step(); mon_en = 1'b1; step(); step();
        rst_next = 1'b0;
        step();
        // lone I-fill, then a D write-through
        set_i(16'h1236); wait_idle();
        set_d(1'b1, 16'h0A02, 16'hBEEF); wait_idle();
        // reset while the fill is receiving word 3
        set_i(16'h4444); step();
        for (int n = 0; n < 40 && cur + 1 != m_t0 + ML + 3; n++) step();
        rst_next = 1'b1; step(); rst_next = 1'b0;
        repeat (8) step();
        // ties after reset: D, I, then D, I, D
        set_i(16'h2000); set_d(1'b0, 16'h3010, 16'h0); wait_idle();
        rearm_d = 1; set_i(16'h2222); set_d(1'b0, 16'h3050, 16'h0); wait_idle();
        // I-cache drops its request after acceptance
        force_drop_i = 1'b1; set_i(16'h5678); wait_idle();
        // new request held through the previous done cycle
        set_d(1'b0, 16'h6000, 16'h0); repeat (3) step();
        set_i(16'h7000); wait_idle();
        set_d(1'b1, 16'h8008, 16'h1234); repeat (2) step();
        set_i(16'h9000); wait_idle();
        rand_mode = 1'b1; repeat (1500) step(); rand_mode = 1'b0;
        wait_idle();
        repeat (ML + 2) step();
        chk("queues_drained", 64'(mq.size() + dq.size() + doneq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, which is the cycles from a read issue to its mem_data_valid.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, which is the number of 16-bit words per cache block (16-byte block).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports icache_req (input, 1) and icache_addr (input, 16): I-cache miss fill request and miss byte address.
REQ-006 SHALL have ports dcache_req (input, 1), dcache_we (input, 1), dcache_addr (input, 16) and dcache_wdata (input, 16): D-cache request, write-through flag (1) vs fill (0), byte address, and write data.
REQ-007 SHALL have ports icache_grant and dcache_grant, output, 1 bit each: requester is being served.
REQ-008 SHALL have ports icache_data_valid and dcache_data_valid, output, 1 bit each: fill word present on rdata.
REQ-009 SHALL have ports rdata (output, 16) and word_idx (output, 3): fill word and its index within the block.
REQ-010 SHALL have ports fill_done (output, 1) and write_done (output, 1): single-cycle completion pulses.
REQ-011 SHALL have ports mem_enable, mem_wr, mem_addr[15:0] and mem_wdata[15:0], all outputs, driving main memory.
REQ-012 SHALL have ports mem_rdata (input, 16) and mem_data_valid (input, 1), returned from main memory.

Function
REQ-013 SHALL implement states IDLE, FILL and WRITE.
REQ-014 SHALL, in IDLE, accept a pending request; when both requesters are pending, the one not granted last wins (round-robin); last_grant resets to I-cache, so D-cache wins the first tie.
REQ-015 SHALL treat requests as level signals; requesters hold req/addr/data stable until done, and the block SHALL latch the address and data at acceptance.
REQ-016 SHALL assert the grant from the cycle after acceptance through the done-pulse cycle inclusive, and SHALL keep grants one-hot or zero.
REQ-017 SHALL, for an accepted fill (icache_req, or dcache_req with dcache_we=0), enter FILL with the latched base {addr[15:4],4'b0}.
REQ-018 SHALL, in FILL, issue one read per cycle for BLOCK_WORDS consecutive cycles with mem_enable=1, mem_wr=0 and mem_addr = base + 2*issue_cnt.
REQ-019 SHALL, in FILL, on each mem_data_valid, pass mem_rdata to rdata combinationally, set word_idx to recv_cnt, pulse the granted requester's data_valid, and increment recv_cnt.
REQ-020 SHALL pulse fill_done in the same cycle as the BLOCK_WORDS-th valid, then return to IDLE on the next edge; with default parameters this gives first data 4 cycles after the first issue and fill_done 11 cycles after the first issue.
REQ-021 SHALL, for an accepted write (dcache_we=1), enter WRITE for exactly MEM_LATENCY cycles, driving mem_enable=1, mem_wr=1, mem_addr=latched addr and mem_wdata=latched data in the first cycle only, and pulsing write_done in the last cycle.
REQ-022 SHALL gate data_valid outputs by state FILL, ignoring mem_data_valid in IDLE or WRITE.
REQ-023 SHALL have a requester dropping req mid-transaction not abort the transaction.
REQ-024 SHALL NOT accept a new request in the done-pulse cycle; arbitration resumes in IDLE on the following cycle.
REQ-025 SHALL drive mem_enable, mem_wr, mem_addr and mem_wdata to 0 whenever no access is issued.

Reset
REQ-026 SHALL, when rst=1 at an edge, enter IDLE, clear issue_cnt, recv_cnt and last_grant, and drive every output to 0 in the following cycle.
REQ-027 SHALL, on reset mid-FILL or mid-WRITE, abandon the transaction, and SHALL ignore in-flight memory returns after reset.

Verification
REQ-028 SHALL verify a lone I-fill: icache_addr=16'h1236 -> mem_addr 1230,1232,…,123E on 8 consecutive cycles, icache_data_valid with word_idx 0..7, one fill_done, and icache_grant only.
REQ-029 SHALL verify a D-write: dcache_we=1, addr=16'h0A02, wdata=16'hBEEF -> one cycle mem_enable=1, mem_wr=1 carrying those values, write_done 3 cycles later, and grant high for 4 cycles.
REQ-030 SHALL verify a tie after reset: both reqs high -> D served first, then I; with both held high again, the grant order alternates D, I, D.
REQ-031 SHALL verify reset mid-fill: rst at recv_cnt=3 -> all outputs 0, and trailing mem_data_valid pulses produce no data_valid.
REQ-032 SHALL verify request drop: icache_req deasserted after acceptance -> all 8 words still returned and fill_done pulsed.
REQ-033 SHALL verify back-to-back operation: a new request held through a done cycle is not accepted in that done cycle, and its grant rises 2 cycles later.
